// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: MIPS32 instruction store, filled over a streaming loader port, then serving one registered fetch per cycle.
// Build option IMEM_PARITY_EN adds a per-word even-parity bit that is checked on every in-range read.
module imem_fetch_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned AW        = 10,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic        clk1,
    input  logic        rst_n,

    // Fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_oob,
    output logic        o_busy,

    // Loader port
    input  logic        ld_start,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,

    output logic        o_perr,
    output logic        o_dbg_state
);

    // Loader handshake: a word moves on any posedge where ld_valid && ld_ready
    // and ld_start is low; ld_ready is high exactly while in LOAD, and the
    // loader may not retract ld_data until that edge.
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_q;
    logic [AW-1:0] wptr_q;
    logic [31:0]   o_data_q;
    logic          o_valid_q;
    logic          o_oob_q;
    logic          o_perr_q;

    logic [31:0]   mem [DEPTH];

    logic          ld_fire;
    logic          store_full;
    logic          addr_oob;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic          rd_bad;

    assign ld_fire    = (state_q == ST_LOAD) && ld_valid && !ld_start;
    assign store_full = (wptr_q == AW'(DEPTH - 1));
    assign addr_oob   = |i_addr[31:AW];
    assign rd_idx     = i_addr[AW-1:0];
    assign rd_word    = mem[rd_idx];

    // The array has no reset so a core reset keeps the loaded program.
    always_ff @(posedge clk1) begin
        if (ld_fire) begin
            mem[wptr_q] <= ld_data;
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk1) begin
        if (ld_fire) begin
            par_mem[wptr_q] <= ^ld_data;
        end
    end

    assign rd_bad = (^rd_word) != par_mem[rd_idx];
`else
    assign rd_bad = 1'b0;
`endif

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            wptr_q    <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_oob_q   <= 1'b0;
            o_perr_q  <= 1'b0;
        end else begin
            o_valid_q <= 1'b0;
            o_oob_q   <= 1'b0;
            o_perr_q  <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (ld_start) begin
                        wptr_q <= '0;
                    end else if (ld_valid) begin
                        // Natural wrap returns wptr to 0 once the store is full.
                        wptr_q <= wptr_q + AW'(1);
                        if (ld_last || store_full) begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (ld_start) begin
                        state_q <= ST_LOAD;
                        wptr_q  <= '0;
                    end else if (i_req) begin
                        o_valid_q <= 1'b1;
                        if (addr_oob) begin
                            o_data_q <= HALT_WORD;
                            o_oob_q  <= 1'b1;
                        end else if (rd_bad) begin
                            o_data_q <= HALT_WORD;
                            o_perr_q <= 1'b1;
                        end else begin
                            o_data_q <= rd_word;
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign o_data      = o_data_q;
    assign o_valid     = o_valid_q;
    assign o_oob       = o_oob_q;
    assign o_perr      = o_perr_q;
    assign o_busy      = (state_q == ST_LOAD);
    assign ld_ready    = (state_q == ST_LOAD);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: random load/fetch traffic checked against an array-based reference model.
module tb_imem_fetch_responder;

    localparam int          DEPTH     = 1024;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    logic        clk1;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_oob;
    logic        o_busy;
    logic        ld_start;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        o_perr;
    logic        o_dbg_state;

    imem_fetch_responder dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_oob       (o_oob),
        .o_busy      (o_busy),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .o_perr      (o_perr),
        .o_dbg_state (o_dbg_state)
    );

    // Clock / watchdog
    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not end, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model
    logic [31:0] m_mem [DEPTH];
    bit          m_bad [DEPTH];
    bit          m_loading;
    int          m_wptr;
    logic [31:0] m_last;
    logic [31:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b1;
        m_wptr    = 0;
        m_last    = '0;
        exp_q.delete();
    endtask

    // One clock: predict from current inputs, advance, compare outputs.
    task automatic cycle();
        logic        exp_v    = 1'b0;
        logic        exp_oob  = 1'b0;
        logic        exp_perr = 1'b0;
        logic [31:0] exp_d;
        if (m_loading) begin
            if (ld_start) begin
                m_wptr = 0;
            end else if (ld_valid) begin
                m_mem[m_wptr] = ld_data;
                m_bad[m_wptr] = 1'b0;
                if (ld_last || m_wptr == DEPTH - 1) m_loading = 1'b0;
                m_wptr = (m_wptr + 1) % DEPTH;
            end
        end else if (ld_start) begin
            m_loading = 1'b1;
            m_wptr    = 0;
        end else if (i_req) begin
            exp_v = 1'b1;
            if (i_addr >= 32'(DEPTH)) begin
                exp_d   = HALT_WORD;
                exp_oob = 1'b1;
            end else if (m_bad[i_addr[9:0]]) begin
                exp_d    = HALT_WORD;
                exp_perr = 1'b1;
            end else begin
                exp_d = m_mem[i_addr[9:0]];
            end
            exp_q.push_back(exp_d);
        end
        @(posedge clk1);
        #1;
        check("valid", 32'(o_valid), 32'(exp_v));
        if (exp_v) begin
            m_last = exp_q.pop_front();
            check("data", o_data, m_last);
        end else begin
            check("hold", o_data, m_last);
        end
        check("oob", 32'(o_oob), 32'(exp_oob));
        check("perr", 32'(o_perr), 32'(exp_perr));
        check("busy", 32'(o_busy), 32'(m_loading));
        check("ld_ready", 32'(ld_ready), 32'(m_loading));
        check("state", 32'(o_dbg_state), 32'(!m_loading));
    endtask

    // Driver tasks
    task automatic do_reset();
        rst_n    = 1'b0;
        i_req    = 1'b0;
        i_addr   = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk1);
        #1;
        check("rst_data", o_data, 32'h0);
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_oob", 32'(o_oob), 32'h0);
        check("rst_perr", 32'(o_perr), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h1);
        check("rst_ready", 32'(ld_ready), 32'h1);
        rst_n = 1'b1;
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        ld_valid = 1'b0;
        repeat ($urandom_range(0, 1)) cycle();
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        cycle();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        i_req  = 1'b1;
        i_addr = addr;
        cycle();
        i_req  = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        do_reset();

        // Small program; i_req held during the final transfer must be ignored.
        load_word(32'h0000_0001, 1'b0);
        load_word(32'h0000_0002, 1'b0);
        load_word(32'h0000_0003, 1'b0);
        i_req  = 1'b1;
        i_addr = 32'h2;
        load_word(32'h0000_0004, 1'b1);
        i_req  = 1'b0;
        fetch(32'h2);
        check("tp_addr2", o_data, 32'h0000_0003);
        for (int i = 0; i < 4; i++) begin
            i_req  = 1'b1;
            i_addr = 32'(i);
            cycle();
        end
        i_req = 1'b0;
        cycle();
        fetch(32'h0000_0400);
        check("tp_oob_data", o_data, HALT_WORD);
        fetch(32'hFFFF_FFFF);
        fetch(32'h8000_0003);
        cycle();

`ifdef IMEM_PARITY_EN
        dut.mem[1] = dut.mem[1] ^ 32'h0000_0008;
        m_bad[1]   = 1'b1;
        fetch(32'h1);
        check("tp_perr_data", o_data, HALT_WORD);
        fetch(32'h0);
`endif

        // Full store without ld_last, with gaps on ld_valid.
        ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) load_word($urandom, 1'b0);
        check("full_run_ready", 32'(ld_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            ld_last  = 1'($urandom_range(0, 1));
            cycle();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        fetch(32'h0);

        // Random fetch traffic with loader noise.
        for (int i = 0; i < 300; i++) begin
            i_req = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom;
                if (a[31:10] == '0) a[31] = 1'b1;
            end else begin
                a = 32'($urandom_range(0, DEPTH - 1));
            end
            i_addr   = a;
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = $urandom;
            cycle();
        end
        i_req    = 1'b0;
        ld_valid = 1'b0;

        // ld_start beats i_req; i_req in LOAD is ignored; ld_start in LOAD drops the transfer.
        ld_start = 1'b1;
        i_req    = 1'b1;
        i_addr   = 32'h0;
        cycle();
        ld_start = 1'b0;
        repeat (2) cycle();
        i_req    = 1'b0;
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 32'h1234_5678;
        cycle();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        load_word(32'hDEAD_BEEF, 1'b1);
        fetch(32'h0);
        check("tp_deadbeef", o_data, 32'hDEAD_BEEF);
        fetch(32'h1);

        // Async reset in the middle of a fetch response; memory retained.
        i_req  = 1'b1;
        i_addr = 32'h5;
        cycle();
        i_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid), 32'h0);
        check("midrst_data", o_data, 32'h0);
        check("midrst_busy", 32'(o_busy), 32'h1);
        check("midrst_ready", 32'(ld_ready), 32'h1);
        model_reset();
        @(negedge clk1);
        rst_n = 1'b1;
        load_word(32'h0000_0011, 1'b1);
        fetch(32'h5);
        fetch(32'h0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
